l1i_fill_unit: RTL and testbench

Refill engine on the write side of the L1 instruction cache. On a fill request for a cache line index it reads one `BLOCK_SIZE`-byte block from instruction memory over a narrow request/valid bus, one beat at a time, and assembles the beats into a full line. It then issues a single-cycle write (enable, line address, block) into the cache's instruction-write port. It sits between the memory interface and the L1I, and is the sole producer of cache line writes.

---
 rtl/l1i_fill_unit_if.sv | 38 +++
 rtl/l1i_fill_unit.sv | 116 +++++++++++
 tb/tb_l1i_fill_unit.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1i_fill_unit_if.sv
// l1i_fill_unit_if: fill-request, memory-beat and cache-write signals of the
// L1I refill engine.
//   master : the fill unit (drives busy/memRead/memAddress/write*/block).
//   slave  : the environment (fill requester, instruction memory, L1I).
interface l1i_fill_unit_if #(
  parameter int unsigned BLOCK_SIZE    = 32,
  parameter int unsigned BITS_PER_BYTE = 8,
  parameter int unsigned MEM_WIDTH     = 32
);
  localparam int unsigned LINE_W = BLOCK_SIZE * BITS_PER_BYTE;

  logic                 fillRequest_i;
  logic [15:0]          fillAddress_i;
  logic                 abort_i;
  logic                 busy_o;
  logic                 memRead_o;
  logic [15:0]          memAddress_o;
  logic                 memReady_i;
  logic                 memValid_i;
  logic [MEM_WIDTH-1:0] memData_i;
  logic                 writeEnable_o;
  logic [15:0]          writeAddress_o;
  logic [LINE_W-1:0]    block_o;

  modport master (
    input  fillRequest_i, fillAddress_i, abort_i,
    input  memReady_i, memValid_i, memData_i,
    output busy_o, memRead_o, memAddress_o,
    output writeEnable_o, writeAddress_o, block_o
  );

  modport slave (
    output fillRequest_i, fillAddress_i, abort_i,
    output memReady_i, memValid_i, memData_i,
    input  busy_o, memRead_o, memAddress_o,
    input  writeEnable_o, writeAddress_o, block_o
  );
endinterface

// File: rtl/l1i_fill_unit.sv
// l1i_fill_unit: L1 instruction-cache refill engine. Reads one cache line from
// instruction memory one MEM_WIDTH beat at a time (one beat outstanding),
// assembles it, then issues a single-cycle line write to the L1I.
// Ports:
//   clock_i : rising-edge clock
//   reset_i : asynchronous active-low reset
//   bus     : fill request/abort, memory request/valid beat bus and
//             cache write port (see l1i_fill_unit_if)
module l1i_fill_unit #(
  parameter int unsigned BLOCK_SIZE    = 32,
  parameter int unsigned BITS_PER_BYTE = 8,
  parameter int unsigned MEM_WIDTH     = 32
) (
  input  logic               clock_i,
  input  logic               reset_i,
  l1i_fill_unit_if.master    bus
);
  localparam int unsigned LINE_W     = BLOCK_SIZE * BITS_PER_BYTE;
  localparam int unsigned BEATS      = LINE_W / MEM_WIDTH;
  localparam int unsigned BEAT_BYTES = MEM_WIDTH / BITS_PER_BYTE;
  localparam int unsigned K_W        = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  logic [1:0]        r_state;
  logic [K_W-1:0]    r_k;
  logic [15:0]       r_line;
  logic [15:0]       r_memAddress;
  logic              r_busy;
  logic              r_memRead;
  logic              r_writeEnable;
  logic [LINE_W-1:0] r_block;

  logic [K_W-1:0]    w_kNext;
  logic              w_lastBeat;
  logic [15:0]       w_firstAddr;
  logic [15:0]       w_nextAddr;

  // Byte addresses are formed in 32 bits and truncated, so line indices whose
  // byte offset crosses 64 KiB wrap around to low memory.
  always_comb begin
    w_kNext     = r_k + K_W'(1);
    w_lastBeat  = (r_k == K_W'(BEATS - 1));
    w_firstAddr = 16'(32'(bus.fillAddress_i) * BLOCK_SIZE);
    w_nextAddr  = 16'(32'(r_line) * BLOCK_SIZE + 32'(w_kNext) * BEAT_BYTES);
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state       <= S_IDLE;
      r_k           <= '0;
      r_line        <= '0;
      r_memAddress  <= '0;
      r_busy        <= 1'b0;
      r_memRead     <= 1'b0;
      r_writeEnable <= 1'b0;
      r_block       <= '0;
    end else if (r_state != S_IDLE && bus.abort_i) begin
      // Abort wins over every transition, including WAIT->WRITE and leaving WRITE.
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_memRead     <= 1'b0;
      r_writeEnable <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A simultaneous abort also blocks acceptance here.
          if (bus.fillRequest_i && !bus.abort_i) begin
            r_state      <= S_REQ;
            r_line       <= bus.fillAddress_i;
            r_k          <= '0;
            r_block      <= '0;
            r_busy       <= 1'b1;
            r_memRead    <= 1'b1;
            r_memAddress <= w_firstAddr;
          end
        end
        S_REQ: begin
          if (bus.memReady_i) begin
            r_state   <= S_WAIT;
            r_memRead <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.memValid_i) begin
            r_block[r_k*MEM_WIDTH +: MEM_WIDTH] <= bus.memData_i;
            if (w_lastBeat) begin
              r_state       <= S_WRITE;
              r_writeEnable <= 1'b1;
            end else begin
              r_state      <= S_REQ;
              r_k          <= w_kNext;
              r_memRead    <= 1'b1;
              r_memAddress <= w_nextAddr;
            end
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_writeEnable <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o         = r_busy;
  assign bus.memRead_o      = r_memRead;
  assign bus.memAddress_o   = r_memAddress;
  assign bus.writeEnable_o  = r_writeEnable;
  assign bus.writeAddress_o = r_line;
  assign bus.block_o        = r_block;
endmodule

// File: tb/tb_l1i_fill_unit.sv
// Directed testbench for l1i_fill_unit with a programmable one-beat memory.
module tb_l1i_fill_unit;
  localparam int unsigned LINE_W = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  l1i_fill_unit_if #(.BLOCK_SIZE(32), .BITS_PER_BYTE(8), .MEM_WIDTH(32)) bus ();

  l1i_fill_unit #(.BLOCK_SIZE(32), .BITS_PER_BYTE(8), .MEM_WIDTH(32)) dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  // Stimulus variables
  logic        fill_req = 1'b0;
  logic [15:0] fill_addr = '0;
  logic        abort = 1'b0;
  logic        r_ready = 1'b0;
  logic        r_valid = 1'b0;
  logic [31:0] r_data = '0;
  logic        stray_valid = 1'b0;
  logic [31:0] stray_data = '0;
  logic [31:0] data_base = 32'h11111111;

  assign bus.fillRequest_i = fill_req;
  assign bus.fillAddress_i = fill_addr;
  assign bus.abort_i       = abort;
  assign bus.memReady_i    = r_ready;
  assign bus.memValid_i    = r_valid | stray_valid;
  assign bus.memData_i     = stray_valid ? stray_data : r_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model state
  int ready_stall [0:15];
  int valid_delay [0:15];
  logic [15:0] addr_log  [0:255];
  logic [15:0] stall_log [0:255];
  int acnt = 0, scnt = 0;
  int beat = 0, rwait = 0, vwait = 0;
  bit pending = 0;

  // Write-port monitor
  int wcount = 0, wcyc = 0;
  logic [15:0]       waddr = '0;
  logic [LINE_W-1:0] wblock = '0;

  initial begin
    for (int i = 0; i < 16; i++) begin ready_stall[i] = 0; valid_delay[i] = 0; end
  end

  // Memory responder: drives ready/valid at negedges, infers handshakes at the
  // following negedge from what it drove.
  initial begin
    forever begin
      @(negedge clk);
      if (!bus.busy_o) begin
        pending = 0; beat = 0; rwait = 0; vwait = 0; r_ready = 0; r_valid = 0;
      end else begin
        if (r_ready) begin pending = 1; vwait = 0; end
        else if (r_valid) begin pending = 0; beat++; rwait = 0; end
        r_ready = 0; r_valid = 0;
        if (pending) begin
          if (vwait < valid_delay[beat]) vwait++;
          else begin r_valid = 1; r_data = 32'(data_base * 32'(beat + 1)); end
        end else if (bus.memRead_o) begin
          if (rwait < ready_stall[beat]) begin
            rwait++; stall_log[scnt[7:0]] = bus.memAddress_o; scnt++;
          end else begin
            r_ready = 1; addr_log[acnt[7:0]] = bus.memAddress_o; acnt++;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.writeEnable_o) begin
        wcount++; wcyc = cyc; waddr = bus.writeAddress_o; wblock = bus.block_o;
      end
    end
  end

  function automatic logic [LINE_W-1:0] exp_block(input logic [31:0] base, input int nbeats);
    logic [LINE_W-1:0] b;
    b = '0;
    for (int k = 0; k < nbeats; k++) b[k*32 +: 32] = 32'(base * 32'(k + 1));
    return b;
  endfunction

  // Request a fill; must be called away from a posedge. Returns E0 cycle count.
  task automatic do_request(input logic [15:0] line, output int e0);
    fill_req = 1'b1; fill_addr = line;
    @(posedge clk); #1; e0 = cyc;
    @(negedge clk); fill_req = 1'b0;
  endtask

  task automatic wait_idle(input string name, output int done_cyc);
    bit ok;
    ok = 0;
    done_cyc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (!bus.busy_o) begin ok = 1; done_cyc = cyc; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s_timeout: busy_o still 1 after 300 cycles, required 0", name); end
  endtask

  task automatic wait_beat(input int b, input bit need_pending);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (beat == b && (!need_pending || pending)) begin ok = 1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL wait_beat_timeout: beat %0d never reached", b); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b required 0", bus.busy_o); end
    n_checks++; if (bus.memRead_o !== 1'b0) begin n_fail++; $display("FAIL rst_memRead: got %0b required 0", bus.memRead_o); end
    n_checks++; if (bus.writeEnable_o !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %0b required 0", bus.writeEnable_o); end
    n_checks++; if (bus.memAddress_o !== 16'h0) begin n_fail++; $display("FAIL rst_memAddr: got %0h required 0", bus.memAddress_o); end
    n_checks++; if (bus.writeAddress_o !== 16'h0) begin n_fail++; $display("FAIL rst_wAddr: got %0h required 0", bus.writeAddress_o); end
    n_checks++; if (bus.block_o !== '0) begin n_fail++; $display("FAIL rst_block: got %0h required 0", bus.block_o); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int e0, a0, w0, done;
    logic [LINE_W-1:0] exp;
    a0 = acnt; w0 = wcount; data_base = 32'h11111111;
    do_request(16'h0003, e0);
    wait_idle("basic", done);
    n_checks++; if (acnt - a0 !== 8) begin n_fail++; $display("FAIL basic_nreq: got %0d required 8", acnt - a0); end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (addr_log[8'(a0 + k)] !== 16'(16'h0060 + 4*k)) begin
        n_fail++; $display("FAIL basic_addr%0d: got %0h required %0h", k, addr_log[8'(a0 + k)], 16'(16'h0060 + 4*k));
      end
    end
    n_checks++; if (wcount - w0 !== 1) begin n_fail++; $display("FAIL basic_wcount: got %0d required 1", wcount - w0); end
    n_checks++; if (wcyc - e0 !== 16) begin n_fail++; $display("FAIL basic_we_edge: got %0d required 16", wcyc - e0); end
    n_checks++; if (done - e0 !== 17) begin n_fail++; $display("FAIL basic_busy_fall: got %0d required 17", done - e0); end
    n_checks++; if (waddr !== 16'h0003) begin n_fail++; $display("FAIL basic_waddr: got %0h required 3", waddr); end
    exp = exp_block(32'h11111111, 8);
    n_checks++; if (wblock !== exp) begin n_fail++; $display("FAIL basic_block: got %0h required %0h", wblock, exp); end
    n_checks++; if (wblock[255:224] !== 32'h88888888) begin n_fail++; $display("FAIL basic_top_beat: got %0h required 88888888", wblock[255:224]); end
    n_checks++; if (bus.block_o !== exp) begin n_fail++; $display("FAIL basic_block_hold: got %0h required %0h", bus.block_o, exp); end
  endtask

  task automatic test_stalls;
    int e0, s0, w0, done;
    s0 = scnt; w0 = wcount;
    ready_stall[2] = 3; valid_delay[5] = 2;
    do_request(16'h0003, e0);
    wait_idle("stall", done);
    ready_stall[2] = 0; valid_delay[5] = 0;
    n_checks++; if (scnt - s0 !== 3) begin n_fail++; $display("FAIL stall_count: got %0d required 3", scnt - s0); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (stall_log[8'(s0 + i)] !== 16'h0068) begin n_fail++; $display("FAIL stall_addr%0d: got %0h required 68", i, stall_log[8'(s0 + i)]); end
    end
    n_checks++; if (wcount - w0 !== 1) begin n_fail++; $display("FAIL stall_wcount: got %0d required 1", wcount - w0); end
    n_checks++; if (wcyc - e0 !== 21) begin n_fail++; $display("FAIL stall_we_edge: got %0d required 21", wcyc - e0); end
    n_checks++; if (wblock !== exp_block(32'h11111111, 8)) begin n_fail++; $display("FAIL stall_block: got %0h required %0h", wblock, exp_block(32'h11111111, 8)); end
  endtask

  task automatic test_wrap;
    int e0, a0, done;
    a0 = acnt;
    do_request(16'h0800, e0);
    wait_idle("wrap", done);
    n_checks++; if (addr_log[8'(a0)] !== 16'h0000) begin n_fail++; $display("FAIL wrap_first: got %0h required 0", addr_log[8'(a0)]); end
    n_checks++; if (addr_log[8'(a0 + 7)] !== 16'h001C) begin n_fail++; $display("FAIL wrap_last: got %0h required 1c", addr_log[8'(a0 + 7)]); end
    n_checks++; if (waddr !== 16'h0800) begin n_fail++; $display("FAIL wrap_waddr: got %0h required 800", waddr); end
  endtask

  task automatic test_abort;
    int e0, w0;
    logic [LINE_W-1:0] exp;
    w0 = wcount;
    valid_delay[4] = 5;
    do_request(16'h0004, e0);
    wait_beat(4, 1);
    abort = 1'b1; fill_req = 1'b1; fill_addr = 16'h0007;
    @(posedge clk); #1;
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0b required 0", bus.busy_o); end
    n_checks++; if (bus.memRead_o !== 1'b0) begin n_fail++; $display("FAIL abort_memRead: got %0b required 0", bus.memRead_o); end
    @(negedge clk); abort = 1'b0; fill_req = 1'b0;
    valid_delay[4] = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_req_ignored: busy got %0b required 0", bus.busy_o); end
    stray_valid = 1'b1; stray_data = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    stray_valid = 1'b0;
    @(negedge clk);
    exp = exp_block(32'h11111111, 4);
    n_checks++; if (bus.block_o !== exp) begin n_fail++; $display("FAIL abort_stray_block: got %0h required %0h", bus.block_o, exp); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_stray_busy: got %0b required 0", bus.busy_o); end
    n_checks++; if (wcount - w0 !== 0) begin n_fail++; $display("FAIL abort_no_write: got %0d required 0", wcount - w0); end
  endtask

  task automatic test_back_to_back;
    int e0, e1, a0, w0, done;
    w0 = wcount;
    do_request(16'h0002, e0);
    wait_beat(3, 0);
    fill_req = 1'b1; fill_addr = 16'h0009;
    @(negedge clk); fill_req = 1'b0;
    wait_idle("busyreq", done);
    n_checks++; if (wcount - w0 !== 1) begin n_fail++; $display("FAIL busyreq_wcount: got %0d required 1", wcount - w0); end
    n_checks++; if (waddr !== 16'h0002) begin n_fail++; $display("FAIL busyreq_waddr: got %0h required 2", waddr); end
    a0 = acnt;
    do_request(16'h0009, e1);
    n_checks++; if (e1 - e0 !== 18) begin n_fail++; $display("FAIL busyreq_next_edge: got %0d required 18", e1 - e0); end
    wait_idle("busyreq2", done);
    n_checks++; if (addr_log[8'(a0)] !== 16'h0120) begin n_fail++; $display("FAIL busyreq_addr: got %0h required 120", addr_log[8'(a0)]); end
    n_checks++; if (waddr !== 16'h0009) begin n_fail++; $display("FAIL busyreq_waddr2: got %0h required 9", waddr); end
  endtask

  task automatic test_async_reset;
    int e0, w0, done;
    logic [LINE_W-1:0] exp;
    w0 = wcount;
    data_base = 32'h11111111;
    do_request(16'h0005, e0);
    wait_beat(6, 0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %0b required 0", bus.busy_o); end
    n_checks++; if (bus.memRead_o !== 1'b0) begin n_fail++; $display("FAIL arst_memRead: got %0b required 0", bus.memRead_o); end
    n_checks++; if (bus.memAddress_o !== 16'h0) begin n_fail++; $display("FAIL arst_memAddr: got %0h required 0", bus.memAddress_o); end
    n_checks++; if (bus.writeAddress_o !== 16'h0) begin n_fail++; $display("FAIL arst_wAddr: got %0h required 0", bus.writeAddress_o); end
    n_checks++; if (bus.block_o !== '0) begin n_fail++; $display("FAIL arst_block: got %0h required 0", bus.block_o); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (wcount - w0 !== 0) begin n_fail++; $display("FAIL arst_no_write: got %0d required 0", wcount - w0); end
    data_base = 32'h01010101;
    do_request(16'h0006, e0);
    wait_idle("arst", done);
    exp = exp_block(32'h01010101, 8);
    n_checks++; if (wcount - w0 !== 1) begin n_fail++; $display("FAIL arst_wcount: got %0d required 1", wcount - w0); end
    n_checks++; if (waddr !== 16'h0006) begin n_fail++; $display("FAIL arst_waddr: got %0h required 6", waddr); end
    n_checks++; if (wblock !== exp) begin n_fail++; $display("FAIL arst_block_new: got %0h required %0h", wblock, exp); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stalls;
    test_wrap;
    test_abort;
    test_back_to_back;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
